// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Fetch-queue entry layout, default depth, exception code.
package if_fetch_unit_pkg;

  localparam int FQ_DEPTH_DEF = 2;

  localparam logic [4:0] EXC_ADEL = 5'h04;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        adel;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch unit bus bundle: icache request/response and
// the decoupled instruction output towards decode.
interface if_fetch_unit_if;

  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_addr_ok;
  logic        icache_data_ok;
  logic [31:0] icache_rdata;

  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_adel;
  logic        out_ready;

  modport master (
    output icache_req, icache_addr,
    output out_valid, out_pc, out_instr, out_adel,
    input  icache_addr_ok, icache_data_ok, icache_rdata,
    input  out_ready
  );

  modport slave (
    input  icache_req, icache_addr,
    input  out_valid, out_pc, out_instr, out_adel,
    output icache_addr_ok, icache_data_ok, icache_rdata,
    output out_ready
  );

endinterface

// File: rtl/if_fetch_unit_fetch_queue.sv
// In-order fetch queue: allocate at tail, fill oldest
// pending entry, retire at head, clear on flush or reset.
module fetch_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEF,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          alloc,
  input  fetch_entry_t  alloc_entry,
  input  logic          fill,
  input  logic [31:0]   fill_data,
  input  logic          retire,
  output fetch_entry_t  head_entry,
  output logic [CW-1:0] count,
  output logic          fill_hit,
  output logic [CW-1:0] pend_after
);

  fetch_entry_t    q [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   fill_idx;
  logic [PW-1:0]   k;
  logic [CW-1:0]   pend;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign head_entry = q[head];

  // Scan youngest-to-oldest so the oldest pending entry wins.
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = '0;
    pend     = '0;
    k        = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      k = PW'((32'(head) + 32'(i)) % DEPTH);
      if (q[k].valid && !q[k].done) begin
        fill_hit = 1'b1;
        fill_idx = k;
      end
    end
    for (int i = 0; i < DEPTH; i++)
      pend = pend + CW'(q[i].valid & ~q[i].done);
    pend_after = pend - CW'(fill & fill_hit);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++)
        q[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (fill && fill_hit) begin
        q[fill_idx].done  <= 1'b1;
        q[fill_idx].instr <= fill_data;
      end
      if (alloc) begin
        q[tail] <= alloc_entry;
        tail    <= inc(tail);
      end
      if (retire) begin
        q[head].valid <= 1'b0;
        head          <= inc(head);
      end
      count <= count + CW'(alloc) - CW'(retire);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues icache requests, tracks
// responses cancelled by redirects, feeds decode in order.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int FQ_DEPTH = FQ_DEPTH_DEF,
  localparam int CW = $clog2(FQ_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     preif_pc,
  output logic            preif_wr,
  input  logic            flush,
  if_fetch_unit_if.master bus
);

  logic [CW-1:0] cancel_cnt;
  logic [CW-1:0] cancel_nxt;
  logic [CW-1:0] q_cnt;
  logic [CW-1:0] pend_after;
  logic          fill_hit;
  fetch_entry_t  head;
  fetch_entry_t  alloc_entry;

  logic space;
  logic aligned;
  logic issue;
  logic misal;
  logic alloc;
  logic cancel_hit;
  logic fill;
  logic retire;

  // In-flight cancelled responses still occupy queue budget.
  assign space   = (int'(q_cnt) + int'(cancel_cnt)) < FQ_DEPTH;
  assign aligned = (preif_pc[1:0] == 2'b00);
  assign issue   = space & ~flush & ~rst & aligned;
  assign misal   = space & ~flush & ~rst & ~aligned;

  assign bus.icache_req  = issue;
  assign bus.icache_addr = preif_pc;

  assign alloc    = (issue & bus.icache_addr_ok) | misal;
  assign preif_wr = ~rst & (flush | alloc);

  assign alloc_entry = '{
    valid: 1'b1,
    done:  misal,
    adel:  misal,
    pc:    preif_pc,
    instr: 32'h0
  };

  assign cancel_hit = bus.icache_data_ok & (cancel_cnt != '0);
  assign fill       = bus.icache_data_ok & (cancel_cnt == '0);

  assign bus.out_valid = head.valid & head.done & ~flush & ~rst;
  assign bus.out_pc    = head.valid ? head.pc    : 32'h0;
  assign bus.out_instr = head.valid ? head.instr : 32'h0;
  assign bus.out_adel  = head.valid & head.adel;
  assign retire        = bus.out_valid & bus.out_ready;

  fetch_queue #(
    .DEPTH(FQ_DEPTH)
  ) u_fq (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .alloc      (alloc),
    .alloc_entry(alloc_entry),
    .fill       (fill),
    .fill_data  (bus.icache_rdata),
    .retire     (retire),
    .head_entry (head),
    .count      (q_cnt),
    .fill_hit   (fill_hit),
    .pend_after (pend_after)
  );

  always_comb begin
    cancel_nxt = cancel_cnt - CW'(cancel_hit);
    if (flush)
      cancel_nxt = cancel_nxt + pend_after;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cancel_cnt <= '0;
    else
      cancel_cnt <= cancel_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.icache_data_ok && cancel_cnt == '0 && !fill_hit));
      assert (int'(cancel_nxt) <= FQ_DEPTH);
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed vector bench for if_fetch_unit.
// Table of per-cycle stimulus/expectations plus a cancel sequence.
module tb_if_fetch_unit;

  localparam logic [31:0] A  = 32'hBFC0_0000;
  localparam logic [31:0] B  = 32'hBFC0_0004;
  localparam logic [31:0] C  = 32'hBFC0_0008;
  localparam logic [31:0] M  = 32'hBFC0_0002;
  localparam logic [31:0] I0 = 32'h3C1D_8000;
  localparam logic [31:0] D1 = 32'h1111_1111;
  localparam logic [31:0] D2 = 32'h2222_2222;
  localparam logic [31:0] D3 = 32'h3333_3333;
  localparam logic [31:0] D4 = 32'h4444_4444;
  localparam logic [31:0] D5 = 32'h5555_5555;
  localparam logic [31:0] D6 = 32'h6666_6666;
  localparam logic [31:0] D7 = 32'h7777_7777;
  localparam logic [31:0] X1 = 32'hDEAD_0001;
  localparam logic [31:0] X2 = 32'hDEAD_0002;
  localparam logic [31:0] X3 = 32'hDEAD_0003;

  logic        clk;
  logic        rst;
  logic [31:0] preif_pc;
  logic        preif_wr;
  logic        flush;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.FQ_DEPTH(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .preif_pc(preif_pc),
    .preif_wr(preif_wr),
    .flush   (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        f;
    logic [31:0] pc;
    logic        ao;
    logic        dk;
    logic [31:0] rd;
    logic        ordy;
    logic        e_req;
    logic        e_wr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_in;
    logic        e_adel;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic add(
    input logic r, input logic f, input logic [31:0] pc,
    input logic ao, input logic dk, input logic [31:0] rd,
    input logic ordy, input logic e_req, input logic e_wr,
    input logic e_ov, input logic [31:0] e_pc,
    input logic [31:0] e_in, input logic e_adel
  );
    vec_t v;
    v.r = r; v.f = f; v.pc = pc; v.ao = ao; v.dk = dk;
    v.rd = rd; v.ordy = ordy; v.e_req = e_req; v.e_wr = e_wr;
    v.e_ov = e_ov; v.e_pc = e_pc; v.e_in = e_in;
    v.e_adel = e_adel;
    vq.push_back(v);
  endtask

  task automatic apply(
    input logic r, input logic f, input logic [31:0] pc,
    input logic ao, input logic dk, input logic [31:0] rd,
    input logic ordy
  );
    @(negedge clk);
    rst = r;
    flush = f;
    preif_pc = pc;
    bus.icache_addr_ok = ao;
    bus.icache_data_ok = dk;
    bus.icache_rdata = rd;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic chk(
    input string name, input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    preif_pc = A;
    bus.icache_addr_ok = 1'b0;
    bus.icache_data_ok = 1'b0;
    bus.icache_rdata = 32'h0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // boot fetch and retire
    add(1,0,A,1,0,0 ,0, 0,0,0,0,0 ,0);
    add(0,0,A,1,0,0 ,1, 1,1,0,0,0 ,0);
    add(0,0,B,0,1,I0,1, 1,0,0,A,0 ,0);
    add(0,0,B,0,0,0 ,1, 1,0,1,A,I0,0);
    add(0,0,B,0,0,0 ,1, 1,0,0,0,0 ,0);
    // full queue backpressure
    add(0,0,A,1,0,0 ,0, 1,1,0,0,0 ,0);
    add(0,0,B,1,0,0 ,0, 1,1,0,A,0 ,0);
    add(0,0,C,1,1,D1,0, 0,0,0,A,0 ,0);
    add(0,0,C,1,1,D2,0, 0,0,1,A,D1,0);
    add(0,0,C,1,0,0 ,1, 0,0,1,A,D1,0);
    add(0,0,C,1,0,0 ,0, 1,1,1,B,D2,0);
    add(0,0,C,0,0,0 ,1, 0,0,1,B,D2,0);
    add(0,0,C,0,1,D3,1, 1,0,0,C,0 ,0);
    add(0,0,C,0,0,0 ,1, 1,0,1,C,D3,0);
    // flush with two pending
    add(0,0,A,1,0,0 ,1, 1,1,0,0,0 ,0);
    add(0,0,B,1,0,0 ,1, 1,1,0,A,0 ,0);
    add(0,1,C,1,0,0 ,1, 0,1,0,A,0 ,0);
    add(0,0,C,1,1,X1,1, 0,0,0,0,0 ,0);
    add(0,0,C,1,1,X2,1, 1,1,0,0,0 ,0);
    add(0,0,C,0,1,D4,1, 1,0,0,C,0 ,0);
    add(0,0,C,0,0,0 ,1, 1,0,1,C,D4,0);
    // flush coincident with data_ok
    add(0,0,A,1,0,0 ,1, 1,1,0,0,0 ,0);
    add(0,0,B,1,0,0 ,1, 1,1,0,A,0 ,0);
    add(0,1,C,1,1,D5,1, 0,1,0,A,0 ,0);
    add(0,0,C,1,1,X3,1, 1,1,0,0,0 ,0);
    add(0,0,C,0,1,D6,1, 1,0,0,C,0 ,0);
    add(0,0,C,0,0,0 ,1, 1,0,1,C,D6,0);
    // misaligned pc
    add(0,0,M,1,0,0 ,0, 0,1,0,0,0 ,0);
    add(0,0,M,1,0,0 ,1, 0,1,1,M,0 ,1);
    add(0,0,A,0,0,0 ,1, 1,0,1,M,0 ,1);
    // reset with two pending
    add(0,0,A,1,0,0 ,1, 1,1,0,0,0 ,0);
    add(0,0,B,1,0,0 ,1, 1,1,0,A,0 ,0);
    add(1,0,C,1,0,0 ,1, 0,0,0,A,0 ,0);
    add(1,0,C,1,0,0 ,1, 0,0,0,0,0 ,0);
    add(0,0,C,1,0,0 ,1, 1,1,0,0,0 ,0);
    add(0,0,C,0,1,D7,1, 1,0,0,C,0 ,0);
    add(0,0,C,0,0,0 ,1, 1,0,1,C,D7,0);

    foreach (vq[i]) begin
      vec_t v;
      v = vq[i];
      apply(v.r, v.f, v.pc, v.ao, v.dk, v.rd, v.ordy);
      checks++;
      if ({bus.icache_req, preif_wr, bus.out_valid, bus.out_pc,
           bus.out_instr, bus.out_adel} !==
          {v.e_req, v.e_wr, v.e_ov, v.e_pc, v.e_in, v.e_adel}) begin
        errors++;
        $display("FAIL step%0d req/wr/ov/pc/instr/adel actual=%b/%b/%b/%h/%h/%b expected=%b/%b/%b/%h/%h/%b",
          i, bus.icache_req, preif_wr, bus.out_valid, bus.out_pc,
          bus.out_instr, bus.out_adel, v.e_req, v.e_wr, v.e_ov,
          v.e_pc, v.e_in, v.e_adel);
      end
    end

    // cancel counter walk-down after a two-pending flush
    apply(0,0,A,1,0,0 ,1);
    chk("seq_acc1", {31'h0, preif_wr}, 32'd1);
    apply(0,0,B,1,0,0 ,1);
    chk("seq_acc2", {31'h0, preif_wr}, 32'd1);
    apply(0,1,C,0,0,0 ,1);
    chk("seq_flush_wr", {31'h0, preif_wr}, 32'd1);
    apply(0,0,C,0,1,X1,1);
    chk("seq_cancel2", 32'(dut.cancel_cnt), 32'd2);
    chk("seq_req_blk", {31'h0, bus.icache_req}, 32'd0);
    apply(0,0,C,0,1,X2,1);
    chk("seq_cancel1", 32'(dut.cancel_cnt), 32'd1);
    chk("seq_ov_disc", {31'h0, bus.out_valid}, 32'd0);
    apply(0,0,C,0,0,0 ,1);
    chk("seq_cancel0", 32'(dut.cancel_cnt), 32'd0);
    chk("seq_pc_empty", bus.out_pc, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
